// File: rtl/clock_pkg.sv
// Shared types and constants for the digital-clock timekeeping controller.
// TWELVE_HOUR_EN selects the 12-hour display conversion helper's use in the top.
package clock_pkg;

  localparam int unsigned SEC_W  = 6;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned HOUR_W = 5;

  localparam logic [SEC_W-1:0]  SEC_MAX     = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX     = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX    = 5'd23;
  localparam logic [HOUR_W-1:0] HOUR_OFFSET = 5'd12;

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StSetHours = 2'd1,
    StSetMins  = 2'd2
  } state_e;

  typedef struct packed {
    logic              pm;
    logic [HOUR_W-1:0] hours;
  } hour12_t;

  // 0 shows as 12 AM, 12 as 12 PM, 13..23 as 1..11 PM.
  function automatic hour12_t to_12h(logic [HOUR_W-1:0] h24);
    hour12_t r;
    r.pm = (h24 >= HOUR_OFFSET);
    if (h24 == '0) begin
      r.hours = HOUR_OFFSET;
    end else if (h24 > HOUR_OFFSET) begin
      r.hours = h24 - HOUR_OFFSET;
    end else begin
      r.hours = h24;
    end
    return r;
  endfunction

endpackage

// File: rtl/clock_time_ctrl_if.sv
// Button inputs and time/display outputs of the clock controller.
// TWELVE_HOUR_EN adds the pm signal.
interface clock_time_ctrl_if;
  import clock_pkg::*;

  logic              btn_mode;
  logic              btn_inc;
  logic [SEC_W-1:0]  secs;
  logic [MIN_W-1:0]  mins;
  logic [HOUR_W-1:0] hours;
  state_e            state;
  logic              sec_tick;
  logic              blink_hide;
`ifdef TWELVE_HOUR_EN
  logic              pm;

  modport master (
    output btn_mode, btn_inc,
    input  secs, mins, hours, state, sec_tick, blink_hide, pm
  );

  modport slave (
    input  btn_mode, btn_inc,
    output secs, mins, hours, state, sec_tick, blink_hide, pm
  );
`else
  modport master (
    output btn_mode, btn_inc,
    input  secs, mins, hours, state, sec_tick, blink_hide
  );

  modport slave (
    input  btn_mode, btn_inc,
    output secs, mins, hours, state, sec_tick, blink_hide
  );
`endif

endinterface

// File: rtl/tick_gen.sv
// Terminal-count divider: counts 0..Count-1 while enabled and pulses on the last count.
// Clear forces the count to 0 but does not mask the pulse of the current cycle.
module tick_gen #(
  parameter int unsigned Count = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = (Count > 1) ? $clog2(Count) : 1;
  localparam logic [CntW-1:0] Last = CntW'(Count - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clock_time_ctrl.sv
// Timekeeping and set-mode controller: 1 Hz time base, RUN/SET_HOURS/SET_MINS FSM, blink gate.
// TWELVE_HOUR_EN converts the hours output to 12-hour form and adds pm.
module clock_time_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100000000,
  parameter int unsigned BLINK_HZ = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  clock_time_ctrl_if.slave    bus
);

  localparam int unsigned BlinkRaw  = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned BlinkHalf = (BlinkRaw > 0) ? BlinkRaw : 1;

  state_e            state_q, state_d;
  logic [SEC_W-1:0]  secs_q, secs_d;
  logic [MIN_W-1:0]  mins_q, mins_d;
  logic [HOUR_W-1:0] hours_q, hours_d;
  logic              sec_tick_q, sec_tick_d;
  logic              phase_q, phase_d;
  logic              hide_q, hide_d;

  logic tick_1hz;
  logic tick_blink;
  logic state_chg;

  assign state_chg = (state_d != state_q);

  // Cleared from the next state so the divider already reads 0 on entry to a set state.
  tick_gen #(
    .Count (CLK_HZ)
  ) u_sec_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (state_q == StRun),
    .clr_i  (state_d != StRun),
    .tick_o (tick_1hz)
  );

  tick_gen #(
    .Count (BlinkHalf)
  ) u_blink_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (state_q != StRun),
    .clr_i  (state_chg),
    .tick_o (tick_blink)
  );

  always_comb begin
    state_d    = state_q;
    secs_d     = secs_q;
    mins_d     = mins_q;
    hours_d    = hours_q;
    sec_tick_d = 1'b0;
    case (state_q)
      StRun: begin
        // Full carry chain resolves in one cycle.
        if (tick_1hz) begin
          sec_tick_d = 1'b1;
          if (secs_q == SEC_MAX) begin
            secs_d = '0;
            if (mins_q == MIN_MAX) begin
              mins_d  = '0;
              hours_d = (hours_q == HOUR_MAX) ? '0 : hours_q + HOUR_W'(1);
            end else begin
              mins_d = mins_q + MIN_W'(1);
            end
          end else begin
            secs_d = secs_q + SEC_W'(1);
          end
        end
        if (bus.btn_mode) begin
          state_d = StSetHours;
        end
      end
      StSetHours: begin
        if (bus.btn_mode) begin
          state_d = StSetMins;
        end else if (bus.btn_inc) begin
          hours_d = (hours_q == HOUR_MAX) ? '0 : hours_q + HOUR_W'(1);
        end
      end
      StSetMins: begin
        if (bus.btn_mode) begin
          state_d = StRun;
          secs_d  = '0;
        end else if (bus.btn_inc) begin
          mins_d = (mins_q == MIN_MAX) ? '0 : mins_q + MIN_W'(1);
        end
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_comb begin
    phase_d = phase_q;
    if (state_chg) begin
      phase_d = 1'b0;
    end else if (tick_blink) begin
      phase_d = ~phase_q;
    end
    hide_d = phase_d && (state_d != StRun);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      secs_q     <= '0;
      mins_q     <= '0;
      hours_q    <= '0;
      sec_tick_q <= 1'b0;
      phase_q    <= 1'b0;
      hide_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      secs_q     <= secs_d;
      mins_q     <= mins_d;
      hours_q    <= hours_d;
      sec_tick_q <= sec_tick_d;
      phase_q    <= phase_d;
      hide_q     <= hide_d;
    end
  end

  assign bus.secs       = secs_q;
  assign bus.mins       = mins_q;
  assign bus.state      = state_q;
  assign bus.sec_tick   = sec_tick_q;
  assign bus.blink_hide = hide_q;

`ifdef TWELVE_HOUR_EN
  hour12_t h12;
  assign h12       = to_12h(hours_q);
  assign bus.hours = h12.hours;
  assign bus.pm    = h12.pm;
`else
  assign bus.hours = hours_q;
`endif

endmodule

// File: doc/clock_time_ctrl.md
Name: clock_time_ctrl

Overview:
- Timekeeping and set-mode controller for the digital clock.
- Derives a 1 Hz tick from the system clock and keeps seconds, minutes and hours.
- Sequences user time-setting through a 3-state FSM and drives the binary mins/hours inputs of the binary-to-BCD display converter.
- Also produces a blink gate so the display can flash the field being edited.

Parameters:
- CLK_HZ, 100000000, system clock frequency; 1 Hz divider terminal count = CLK_HZ-1.
- BLINK_HZ, 2, blink rate in set modes; half-period = CLK_HZ/(2*BLINK_HZ) cycles.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- btn_mode  in  1  debounced single-cycle pulse; advances the FSM.
- btn_inc  in  1  debounced single-cycle pulse; increments the field being edited.
- secs  out  6  seconds, 0..59.
- mins  out  6  minutes, 0..59; feeds the BCD converter.
- hours  out  5  hours, 0..23 (see Optional Feature); feeds the BCD converter.
- state  out  2  0=RUN, 1=SET_HOURS, 2=SET_MINS.
- sec_tick  out  1  one-cycle pulse when seconds advance.
- blink_hide  out  1  high = blank the field currently being edited.

Behaviour:
- Reset (asynchronous, immediate):
  - secs=mins=hours=0, state=RUN.
  - Both dividers cleared; sec_tick=0, blink_hide=0.
- Clock domain and latency:
  - Single clock domain; all outputs are registered.
  - An input pulse in cycle N is reflected on the outputs in cycle N+1.
- 1 Hz divider:
  - Counts 0..CLK_HZ-1 in RUN only.
  - The cycle at CLK_HZ-1 is the tick; the counter wraps to 0.
  - Held at 0 in the set states.
- RUN, on tick:
  - secs+1 and sec_tick=1 for that cycle.
  - secs 59 -> 0 carries into mins; mins 59 -> 0 carries into hours; hours 23 -> 0.
  - All carries resolve in the same cycle: 23:59:59 -> 00:00:00 in one step.
- RUN, other inputs:
  - btn_inc is ignored.
  - btn_mode -> SET_HOURS.
  - A tick in the same cycle as btn_mode is still applied.
- SET_HOURS:
  - Time is frozen.
  - btn_inc: hours+1, 23 -> 0; no effect on mins.
  - btn_mode -> SET_MINS.
- SET_MINS:
  - btn_inc: mins+1, 59 -> 0; no carry into hours.
  - btn_mode -> RUN; on that transition secs=0 and the 1 Hz divider=0.
- Simultaneous btn_mode and btn_inc:
  - btn_mode wins and btn_inc is dropped.
  - The field of the state being left is unchanged.
- Blink:
  - Divider runs only in the set states and toggles the phase every half-period.
  - blink_hide = phase AND (state != RUN).
  - Every state change resets the phase to 0, so the field is visible on entry.
  - blink_hide=0 in RUN.
- Out-of-range inputs: none possible; all counters saturate-free and wrap as above.
- No illegal-state lockup: encoding 3 returns to RUN on the next clock.

Optional Feature:
- Macro: TWELVE_HOUR_EN.
- Defined:
  - Adds output port pm (1 bit).
  - Internal count stays 0..23; the hours output is converted combinationally from the internal register.
  - Conversion: 0 -> 12/pm=0; 1..11 -> same/pm=0; 12 -> 12/pm=1; 13..23 -> h-12/pm=1.
  - SET_HOURS still steps internal 0..23.
- Undefined: no pm port; hours output = internal 0..23.

Decomposition:
- Package clock_pkg holds:
  - State enum: RUN, SET_HOURS, SET_MINS.
  - Constants: SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, and the 12-hour offset 12.
  - Field widths: SEC_W=6, MIN_W=6, HOUR_W=5.
- One sub-module, tick_gen:
  - Parameterised terminal-count divider with enable and synchronous clear.
  - Outputs a single-cycle pulse.
  - Instanced twice: the 1 Hz tick and the blink half-period.

Test Plan (CLK_HZ=10, BLINK_HZ=1):
- Reset: assert rst_n=0 mid-cycle -> outputs 00:00:00, state=0 without waiting for a clock edge; release, 10 cycles -> secs=1, one sec_tick.
- Rollover: set 23:59 via set modes, return to RUN, 60 ticks -> 00:00:00, mins/hours change on the same cycle as secs wraps.
- Hour wrap: SET_HOURS, 25 btn_inc pulses -> hours=1; mins unchanged.
- Minute wrap: in SET_MINS at mins=59, btn_inc -> mins=0, hours unchanged; btn_mode -> RUN, secs=0, first sec_tick exactly 10 cycles later.
- Simultaneous: in SET_HOURS, btn_mode+btn_inc together -> state=SET_MINS, hours unchanged, blink_hide=0 for the next 5 cycles then 1 for 5.
- TWELVE_HOUR_EN: internal hours 0/12/13 -> hours=12 pm=0 / 12 pm=1 / 1 pm=1.
